// File: rtl/neo_lb_pkg.sv
// Constants shared by the sprite line-buffer writer and the scan-out reader.
package neo_lb_pkg;

  localparam int LB_AW = 9;
  localparam int LB_DW = 12;

  localparam logic [LB_DW-1:0] BACKDROP = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } lb_state_e;

endpackage

// File: rtl/lb_scan_pipe.sv
// Tag pipeline for line-buffer reads: carries each read's address and buffer
// select across the RAM latency, then emits the pixel and its backdrop clear.
module lb_scan_pipe
  import neo_lb_pkg::*;
#(
  parameter int AW = LB_AW,
  parameter int DW = LB_DW
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          launch,
  input  logic [AW-1:0] launch_addr,
  input  logic          launch_sel,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] pix_out,
  output logic          pix_valid,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          clr_sel,
  output logic          tag_early
);

  logic          s1_valid, s2_valid;
  logic [AW-1:0] s1_addr, s2_addr;
  logic          s1_sel, s2_sel;

  always_ff @(posedge CLK) begin
    // NOTE: data registers are reset as well, since the pixel and clear outputs
    // have defined reset values and a reset must drop in-flight clears.
    if (!nRESET) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_sel    <= 1'b0;
      s2_valid  <= 1'b0;
      s2_addr   <= '0;
      s2_sel    <= 1'b0;
      pix_out   <= DW'(BACKDROP);
      pix_valid <= 1'b0;
      clr_we    <= 1'b0;
      clr_addr  <= '0;
      clr_sel   <= 1'b0;
    end else begin
      s1_valid <= launch;
      if (launch) begin
        s1_addr <= launch_addr;
        s1_sel  <= launch_sel;
      end
      s2_valid  <= s1_valid;
      s2_addr   <= s1_addr;
      s2_sel    <= s1_sel;
      pix_valid <= s2_valid;
      clr_we    <= s2_valid;
      if (s2_valid) begin
        pix_out  <= rd_data;
        clr_addr <= s2_addr;
        clr_sel  <= s2_sel;
      end
    end
  end

  // A tag in stage 1 still needs another full CLK; one in stage 2 completes at this edge.
  assign tag_early = s1_valid;

endmodule

// File: rtl/lb_scanout.sv
// Read-side controller for the ping-pong sprite line buffers: scans the buffer
// not being filled, forwards each pixel to the palette and clears it behind the read.
module lb_scanout
  import neo_lb_pkg::*;
#(
  parameter int AW    = LB_AW,
  parameter int WIDTH = 320,
  parameter int DW    = LB_DW
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          CE_PIXEL,
  input  logic          LINE_START,
  input  logic [AW-1:0] START_X,
  output logic          LB_SEL,
  output logic [AW-1:0] RD_ADDR,
  input  logic [DW-1:0] RD_DATA,
  output logic          CLR_WE,
  output logic [AW-1:0] CLR_ADDR,
  output logic          CLR_SEL,
  output logic [DW-1:0] CLR_DATA,
  output logic [DW-1:0] PIX_OUT,
  output logic          PIX_VALID,
  output logic          BUSY
);

  localparam int NW = $clog2(WIDTH + 1);

  lb_state_e     state, state_nx;
  logic [AW-1:0] cursor;
  logic [NW-1:0] n;
  logic          take_pix, last_pix, tag_early;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_nx = state;
    take_pix = (state == ST_ACTIVE) && CE_PIXEL && !LINE_START;
    last_pix = take_pix && (n == NW'(WIDTH - 1));
    if (LINE_START) begin
      state_nx = ST_ACTIVE;
    end else begin
      case (state)
        ST_ACTIVE: if (last_pix) state_nx = ST_DRAIN;
        ST_DRAIN:  if (!tag_early) state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values,
    // so RD_ADDR takes the old cursor while the cursor advances.
    if (!nRESET) begin
      state   <= ST_IDLE;
      LB_SEL  <= 1'b0;
      RD_ADDR <= '0;
      cursor  <= '0;
      n       <= '0;
    end else begin
      state <= state_nx;
      if (LINE_START) begin
        LB_SEL <= ~LB_SEL;
        cursor <= START_X;
        n      <= '0;
      end else if (take_pix) begin
        RD_ADDR <= cursor;
        cursor  <= cursor + AW'(1);
        n       <= n + NW'(1);
      end
    end
  end

  lb_scan_pipe #(
    .AW(AW),
    .DW(DW)
  ) u_pipe (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .launch      (take_pix),
    .launch_addr (cursor),
    .launch_sel  (LB_SEL),
    .rd_data     (RD_DATA),
    .pix_out     (PIX_OUT),
    .pix_valid   (PIX_VALID),
    .clr_we      (CLR_WE),
    .clr_addr    (CLR_ADDR),
    .clr_sel     (CLR_SEL),
    .tag_early   (tag_early)
  );

  assign BUSY     = (state != ST_IDLE);
  assign CLR_DATA = DW'(BACKDROP);

endmodule

// File: tb/tb_lb_scanout.sv
// Bench for lb_scanout: line-buffer RAM model plus a schedule-based reference
// of reads, pixel outputs and clears, with directed scenarios and random traffic.
module tb_lb_scanout;

  localparam int AW    = 9;
  localparam int WIDTH = 4;
  localparam int DW    = 12;
  localparam int DEPTH = 1 << AW;
  localparam int OBS_W = 2 * AW + 2 * DW + 5;
  localparam logic [DW-1:0] BD = 12'hFFF;

  logic          CLK = 1'b0;
  logic          nRESET = 1'b0;
  logic          CE_PIXEL = 1'b0;
  logic          LINE_START = 1'b0;
  logic [AW-1:0] START_X = '0;
  logic          LB_SEL;
  logic [AW-1:0] RD_ADDR;
  logic [DW-1:0] RD_DATA;
  logic          CLR_WE;
  logic [AW-1:0] CLR_ADDR;
  logic          CLR_SEL;
  logic [DW-1:0] CLR_DATA;
  logic [DW-1:0] PIX_OUT;
  logic          PIX_VALID;
  logic          BUSY;

  always #5 CLK = ~CLK;

  lb_scanout #(.AW(AW), .WIDTH(WIDTH), .DW(DW)) dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .CE_PIXEL   (CE_PIXEL),
    .LINE_START (LINE_START),
    .START_X    (START_X),
    .LB_SEL     (LB_SEL),
    .RD_ADDR    (RD_ADDR),
    .RD_DATA    (RD_DATA),
    .CLR_WE     (CLR_WE),
    .CLR_ADDR   (CLR_ADDR),
    .CLR_SEL    (CLR_SEL),
    .CLR_DATA   (CLR_DATA),
    .PIX_OUT    (PIX_OUT),
    .PIX_VALID  (PIX_VALID),
    .BUSY       (BUSY)
  );

  function automatic logic [DW-1:0] pattern(input bit sel, input logic [AW-1:0] a);
    return DW'(a) + (sel ? 12'h100 : 12'h600);
  endfunction

  // Two line buffers with a one-CLK registered read port and a write port for clears.
  logic [DW-1:0] mem [2][DEPTH];
  initial begin
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < DEPTH; a++)
        mem[s][a] = pattern(s[0], AW'(a));
  end
  always @(posedge CLK) begin
    RD_DATA <= mem[LB_SEL][RD_ADDR];
    if (CLR_WE === 1'b1) mem[CLR_SEL][CLR_ADDR] <= CLR_DATA;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: line progress plus a schedule of completions indexed by cycle.
  bit            m_sel, m_reading;
  logic [AW-1:0] m_cursor, m_rd_addr;
  int            m_n, m_drain_end, last_ce_cyc;
  bit            m_cleared [2][DEPTH];
  bit            s_v [8];
  logic [DW-1:0] s_d [8];
  logic [AW-1:0] s_a [8];
  bit            s_s [8];
  logic [DW-1:0] e_pix = BD;
  logic [AW-1:0] e_clr_addr = '0;
  bit            e_clr_sel;

  logic [DW-1:0] pix_log[$];
  int            pix_cyc[$];
  logic [AW-1:0] clr_log[$];
  bit            clr_sel_log[$];
  int            busy_fall = -1;
  bit            prev_busy;

  task automatic clear_logs();
    pix_log.delete();
    pix_cyc.delete();
    clr_log.delete();
    clr_sel_log.delete();
  endtask

  // One CLK: drive inputs, advance the model across the edge, compare every output.
  task automatic step(input bit rst_n, input bit ls, input bit ce, input logic [AW-1:0] sx);
    logic [OBS_W-1:0] obs, exp;
    int slot;
    bit strobe;
    @(negedge CLK);
    nRESET = rst_n; LINE_START = ls; CE_PIXEL = ce; START_X = sx;
    @(posedge CLK);
    cyc++;
    strobe = 1'b0;
    if (!rst_n) begin
      m_sel = 1'b0; m_reading = 1'b0; m_rd_addr = '0; m_drain_end = 0;
      e_pix = BD; e_clr_addr = '0; e_clr_sel = 1'b0;
      for (int i = 0; i < 8; i++) s_v[i] = 1'b0;
    end else begin
      slot = cyc % 8;
      if (s_v[slot]) begin
        strobe = 1'b1;
        e_pix = s_d[slot]; e_clr_addr = s_a[slot]; e_clr_sel = s_s[slot];
        m_cleared[s_s[slot]][s_a[slot]] = 1'b1;
        s_v[slot] = 1'b0;
      end
      if (ls) begin
        m_sel = !m_sel; m_cursor = sx; m_n = 0; m_reading = 1'b1;
      end else if (ce && m_reading) begin
        slot = (cyc + 2) % 8;
        s_v[slot] = 1'b1; s_a[slot] = m_cursor; s_s[slot] = m_sel;
        s_d[slot] = m_cleared[m_sel][m_cursor] ? BD : pattern(m_sel, m_cursor);
        m_rd_addr = m_cursor;
        m_cursor = m_cursor + 1'b1;
        m_n++;
        last_ce_cyc = cyc;
        if (m_n == WIDTH) begin
          m_reading = 1'b0;
          m_drain_end = cyc + 2;
        end
      end
    end
    #1;
    obs = {LB_SEL, RD_ADDR, PIX_VALID, CLR_WE, PIX_OUT, CLR_ADDR, CLR_SEL, CLR_DATA, BUSY};
    exp = {m_sel, m_rd_addr, strobe, strobe, e_pix, e_clr_addr, e_clr_sel, BD,
           m_reading || (cyc < m_drain_end)};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL cycle %0d outputs: got sel=%b rd=%0d pv=%b we=%b pix=%h clr=%0d csel=%b cdata=%h busy=%b; want sel=%b rd=%0d pv=%b we=%b pix=%h clr=%0d csel=%b cdata=%h busy=%b",
               cyc, LB_SEL, RD_ADDR, PIX_VALID, CLR_WE, PIX_OUT, CLR_ADDR, CLR_SEL, CLR_DATA, BUSY,
               m_sel, m_rd_addr, strobe, strobe, e_pix, e_clr_addr, e_clr_sel, BD,
               m_reading || (cyc < m_drain_end));
    end
    if (PIX_VALID === 1'b1) begin pix_log.push_back(PIX_OUT); pix_cyc.push_back(cyc); end
    if (CLR_WE === 1'b1) begin clr_log.push_back(CLR_ADDR); clr_sel_log.push_back(CLR_SEL); end
    if (prev_busy && BUSY === 1'b0) busy_fall = cyc;
    prev_busy = (BUSY === 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom));
    checks++;
    if ({LB_SEL, RD_ADDR, CLR_WE, CLR_ADDR, CLR_DATA, PIX_OUT, PIX_VALID, BUSY} !==
        {1'b0, AW'(0), 1'b0, AW'(0), BD, BD, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got sel=%b rd=%0d we=%b clr=%0d cdata=%h pix=%h pv=%b busy=%b",
               LB_SEL, RD_ADDR, CLR_WE, CLR_ADDR, CLR_DATA, PIX_OUT, PIX_VALID, BUSY);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, (i % 4 == 0), AW'($urandom));
      checks++;
      if (BUSY !== 1'b0) begin
        errors++;
        $display("FAIL idle_busy[%0d]: got %b expected 0", i, BUSY);
      end
    end
  endtask

  task automatic test_basic_line();
    int ce_cyc [4];
    clear_logs();
    step(1'b1, 1'b1, 1'b0, AW'(5));
    checks++;
    if (LB_SEL !== 1'b1) begin errors++; $display("FAIL basic_lb_sel: got %b expected 1", LB_SEL); end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      ce_cyc[k] = cyc;
      checks++;
      if (RD_ADDR !== AW'(5 + k)) begin
        errors++; $display("FAIL basic_rd_addr[%0d]: got %0d expected %0d", k, RD_ADDR, 5 + k);
      end
      repeat (7) step(1'b1, 1'b0, 1'b0, '0);
    end
    checks++;
    if (pix_log.size() != 4 || clr_log.size() != 4) begin
      errors++; $display("FAIL basic_count: got %0d pixels %0d clears expected 4", pix_log.size(), clr_log.size());
    end
    for (int k = 0; k < 4 && k < pix_log.size() && k < clr_log.size(); k++) begin
      checks++;
      if (pix_log[k] !== 12'h105 + 12'(k) || pix_cyc[k] != ce_cyc[k] + 2 ||
          clr_log[k] !== AW'(5 + k) || clr_sel_log[k] !== 1'b1) begin
        errors++;
        $display("FAIL basic_pixel[%0d]: got pix=%h at +%0d clr=%0d sel=%b expected pix=%h at +2 clr=%0d sel=1",
                 k, pix_log[k], pix_cyc[k] - ce_cyc[k], clr_log[k], clr_sel_log[k], 12'h105 + 12'(k), 5 + k);
      end
    end
    checks++;
    if (busy_fall != ce_cyc[3] + 2) begin
      errors++; $display("FAIL basic_busy_fall: got +%0d expected +2", busy_fall - ce_cyc[3]);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a;
    clear_logs();
    step(1'b1, 1'b1, 1'b0, AW'(510));
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      a = AW'(510 + k);
      checks++;
      if (RD_ADDR !== a) begin errors++; $display("FAIL wrap_rd_addr[%0d]: got %0d expected %0d", k, RD_ADDR, a); end
      repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    end
    for (int k = 0; k < 4 && k < pix_log.size(); k++) begin
      a = AW'(510 + k);
      checks++;
      if (pix_log[k] !== pattern(1'b0, a)) begin
        errors++; $display("FAIL wrap_pixel[%0d]: got %h expected %h", k, pix_log[k], pattern(1'b0, a));
      end
    end
  endtask

  task automatic test_ping_pong();
    step(1'b0, 1'b0, 1'b0, '0);
    for (int l = 0; l < 3; l++) begin
      clear_logs();
      step(1'b1, 1'b1, 1'b0, AW'(20 * (l + 1)));
      checks++;
      if (LB_SEL !== 1'(l % 2 == 0)) begin
        errors++; $display("FAIL pingpong_sel[%0d]: got %b expected %b", l, LB_SEL, l % 2 == 0);
      end
      for (int k = 0; k < 4; k++) begin
        step(1'b1, 1'b0, 1'b1, '0);
        repeat (2) step(1'b1, 1'b0, 1'b0, '0);
      end
      repeat (3) step(1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < clr_sel_log.size(); k++) begin
        checks++;
        if (clr_sel_log[k] !== 1'(l % 2 == 0)) begin
          errors++; $display("FAIL pingpong_clr_sel[%0d.%0d]: got %b expected %b", l, k, clr_sel_log[k], l % 2 == 0);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[1][20 + k] !== BD || mem[0][40 + k] !== BD || mem[1][60 + k] !== BD) begin
        errors++; $display("FAIL pingpong_cleared[%0d]: got %h %h %h expected fff", k,
                           mem[1][20 + k], mem[0][40 + k], mem[1][60 + k]);
      end
    end
    checks++;
    if (mem[0][20] !== pattern(1'b0, AW'(20)) || mem[1][40] !== pattern(1'b1, AW'(40))) begin
      errors++; $display("FAIL pingpong_other_buffer: got %h %h expected untouched", mem[0][20], mem[1][40]);
    end
  endtask

  task automatic test_abort();
    int c2;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, AW'(100));
    step(1'b1, 1'b0, 1'b1, '0);
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    c2 = cyc;
    clear_logs();
    step(1'b1, 1'b1, 1'b0, AW'(200));
    checks++;
    if (LB_SEL !== 1'b0) begin errors++; $display("FAIL abort_sel: got %b expected 0", LB_SEL); end
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    checks++;
    if (RD_ADDR !== AW'(200)) begin errors++; $display("FAIL abort_new_start: got %0d expected 200", RD_ADDR); end
    checks++;
    if (pix_log.size() != 1 || clr_log.size() != 1) begin
      errors++; $display("FAIL abort_inflight_count: got %0d expected 1", pix_log.size());
    end else if (pix_log[0] !== pattern(1'b1, AW'(101)) || pix_cyc[0] != c2 + 2 ||
                 clr_log[0] !== AW'(101) || clr_sel_log[0] !== 1'b1) begin
      errors++; $display("FAIL abort_inflight: got pix=%h clr=%0d sel=%b expected pix=%h clr=101 sel=1",
                         pix_log[0], clr_log[0], clr_sel_log[0], pattern(1'b1, AW'(101)));
    end
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, AW'(300));
    checks++;
    if (RD_ADDR !== AW'(200) || LB_SEL !== 1'b1) begin
      errors++; $display("FAIL abort_coincident: got rd=%0d sel=%b expected rd=200 sel=1", RD_ADDR, LB_SEL);
    end
    clear_logs();
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (pix_log.size() != 0) begin errors++; $display("FAIL abort_phantom: got %0d pixels expected 0", pix_log.size()); end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      if (k == 0) begin
        checks++;
        if (RD_ADDR !== AW'(300)) begin errors++; $display("FAIL abort_after_coincident: got %0d expected 300", RD_ADDR); end
      end
      repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    end
    step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (mem[1][101] !== BD || mem[0][101] !== pattern(1'b0, AW'(101))) begin
      errors++; $display("FAIL abort_clear_buffer: got old=%h new=%h expected old=fff new untouched", mem[1][101], mem[0][101]);
    end
  endtask

  task automatic test_reset_midline();
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, AW'(50));
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    clear_logs();
    step(1'b0, 1'b0, 1'b0, '0);
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (pix_log.size() != 0 || clr_log.size() != 0 || BUSY !== 1'b0 || LB_SEL !== 1'b0) begin
      errors++; $display("FAIL reset_midline: got %0d pixels %0d clears busy=%b sel=%b expected 0 0 0 0",
                         pix_log.size(), clr_log.size(), BUSY, LB_SEL);
    end
    checks++;
    if (mem[1][50] !== pattern(1'b1, AW'(50))) begin
      errors++; $display("FAIL reset_midline_clear: got %h expected %h", mem[1][50], pattern(1'b1, AW'(50)));
    end
  endtask

  task automatic test_random();
    int since_ce = 3;
    bit ls, ce, rst_n;
    int bad;
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 1500; i++) begin
      since_ce++;
      rst_n = ($urandom_range(0, 299) != 0);
      ls = ($urandom_range(0, 24) == 0) ||
           (!m_reading && cyc >= m_drain_end && $urandom_range(0, 3) == 0);
      ce = (since_ce >= 3) && ($urandom_range(0, 2) == 0);
      if (ce) since_ce = 0;
      step(rst_n, ls, ce, AW'($urandom));
    end
    repeat (5) step(1'b1, 1'b0, 1'b0, '0);
    for (int s = 0; s < 2; s++) begin
      bad = 0;
      for (int a = 0; a < DEPTH; a++)
        if (mem[s][a] !== (m_cleared[s][a] ? BD : pattern(s[0], AW'(a)))) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL random_buffer_image[%0d]: got %0d wrong words expected 0", s, bad); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_wrap();
    test_ping_pong();
    test_abort();
    test_reset_midline();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
